// File: rtl/keypad_pkg.sv
// Shared definitions for the hex keypad entry block: key map, FSM encoding, column reset pattern.
// Latency: none (constants and pure combinational helpers).
// Backpressure: not applicable.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Column drive for column index 0 (active-low one-hot).
    localparam logic [3:0] COL_IDLE = 4'b1110;

    // Key values indexed by {row, col}; element 0 is row 0 / col 0.
    // Each line lists one row, columns 3 down to 0.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,   // row 3
        4'hC, 4'h9, 4'h8, 4'h7,   // row 2
        4'hB, 4'h6, 4'h5, 4'h4,   // row 1
        4'hA, 4'h3, 4'h2, 4'h1    // row 0
    };

    // True when exactly one row line is pulled low.
    function automatic logic one_low(input logic [3:0] pat);
        return $onehot(~pat);
    endfunction

    // Index of the low bit in a pattern that has exactly one bit low.
    function automatic logic [1:0] low_index(input logic [3:0] pat);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!pat[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan tick generator: reloading down-counter, one-cycle tick every SCAN_INIT+1 clocks.
// Latency: first tick SCAN_INIT+1 cycles after reset release (tick is decoded from the count register).
// Backpressure: none; free-running.
module scan_tick_gen #(
    parameter logic [23:0] SCAN_INIT = 24'h000f00
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;

    // Tick fires while the count sits at zero; that same cycle reloads it.
    always_comb begin
        tick  = (cnt_q == 24'd0);
        cnt_d = tick ? SCAN_INIT : (cnt_q - 24'd1);
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= SCAN_INIT;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/hex_keypad_entry.sv
// Hex keypad scanner: scans a 4x4 matrix, debounces, accepts one key per press, shifts digits into a 4-digit value.
// Latency: 2 clk row sync + (DEBOUNCE_SCANS-1) scan periods from first stable tick, key_valid 1 clk after accepting tick.
// Backpressure: none; key_valid is a single-cycle pulse that the consumer must take when it appears.
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter logic [23:0] SCAN_INIT      = 24'h000f00,
    parameter int          DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clr,
    output logic [3:0]  col,
    output logic [15:0] four_hex_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    logic tick;

    // Two-flop synchronizer for the asynchronous row lines.
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] rs_q, rs_d;

    state_t             state_q, state_d;
    logic [1:0]         col_idx_q, col_idx_d;
    logic [1:0]         row_idx_q, row_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         col_q, col_d;
    logic [15:0]        hex_q, hex_d;
    logic [3:0]         key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_down_q, key_down_d;

    logic               advance;
    logic [CNT_W-1:0]   cnt_inc;
    logic [3:0]         latched_pat;
    logic [3:0]         lookup;

    scan_tick_gen #(
        .SCAN_INIT (SCAN_INIT)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Next-state logic: scan/debounce FSM, stepped only on scan ticks; clr overrides the digit register.
    always_comb begin
        sync1_d     = row;
        rs_d        = sync1_q;
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        cnt_d       = cnt_q;
        hex_d       = hex_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        advance     = 1'b0;
        cnt_inc     = cnt_q + 1'b1;
        latched_pat = ~(4'b0001 << row_idx_q);
        lookup      = KEY_MAP[{row_idx_q, col_idx_q}];

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (one_low(rs_q)) begin
                        row_idx_d = low_index(rs_q);
                        cnt_d     = CNT_W'(1);
                        state_d   = DEBOUNCE;
                    end else begin
                        advance = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (rs_q == latched_pat) begin
                        if (cnt_inc == CNT_DONE) begin
                            state_d     = HELD;
                            cnt_d       = '0;
                            key_down_d  = 1'b1;
                            key_valid_d = 1'b1;
                            key_code_d  = lookup;
                            hex_d       = {hex_q[11:0], lookup};
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Bounce or a different key: drop the candidate and keep scanning.
                        state_d = IDLE;
                        cnt_d   = '0;
                        advance = 1'b1;
                    end
                end
                HELD: begin
                    if (rs_q == 4'b1111) begin
                        if (cnt_inc == CNT_DONE) begin
                            state_d    = IDLE;
                            cnt_d      = '0;
                            key_down_d = 1'b0;
                            advance    = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Any low row restarts the release count; no auto-repeat.
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    key_down_d = 1'b0;
                end
            endcase
        end

        if (advance) col_idx_d = col_idx_q + 2'd1;
        col_d = ~(4'b0001 << col_idx_d);

        if (clr) hex_d = '0;
    end

    // All state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 4'b1111;
            rs_q        <= 4'b1111;
            state_q     <= IDLE;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cnt_q       <= '0;
            col_q       <= COL_IDLE;
            hex_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rs_q        <= rs_d;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            hex_q       <= hex_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign col          = col_q;
    assign four_hex_out = hex_q;
    assign key_code     = key_code_q;
    assign key_valid    = key_valid_q;
    assign key_down     = key_down_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Bench for hex_keypad_entry: keypad matrix model, scoreboard of expected key events, directed scenarios.
// Latency: tick every 4 clk, 3 debounce scans.
// Backpressure: none.
module tb_hex_keypad_entry;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] four_hex_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;

    int checks = 0;
    int errors = 0;

    // Keypad model: a held key pulls its row low while its column is driven low.
    logic       key_active = 1'b0;
    logic [1:0] key_r = 2'd0;
    logic [1:0] key_c = 2'd0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'b1111;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] hex;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always_comb begin
        if (force_en)                              row = force_val;
        else if (key_active && (col[key_c] == 1'b0)) row = ~(4'b0001 << key_r);
        else                                       row = 4'b1111;
    end

    hex_keypad_entry #(
        .SCAN_INIT      (24'd3),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .row          (row),
        .clr          (clr),
        .col          (col),
        .four_hex_out (four_hex_out),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_down     (key_down)
    );

    // Monitor: every key_valid pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_key_valid actual code=%h hex=%h required no pulse", key_code, four_hex_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (key_code !== mon_e.code || four_hex_out !== mon_e.hex) begin
                    errors++;
                    $display("FAIL key_event actual code=%h hex=%h required code=%h hex=%h",
                             key_code, four_hex_out, mon_e.code, mon_e.hex);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Wait for col to change into target; cycles returns the clocks spent.
    task automatic wait_col(input logic [3:0] target, input int budget, output int cycles);
        logic [3:0] prev;
        bit seen;
        seen = 1'b0;
        prev = col;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
            if (col == target && prev != target) seen = 1'b1;
            prev = col;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_col actual=%b required=%b", col, target);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!key_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!key_valid) begin
            errors++;
            $display("FAIL wait_valid actual=0 required=1 within %0d clk", budget);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_up(input int budget);
        int n;
        n = 0;
        while (key_down && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (key_down) begin
            errors++;
            $display("FAIL wait_key_up actual=1 required=0 within %0d clk", budget);
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        key_r = r;
        key_c = c;
        key_active = 1'b1;
    endtask

    task automatic enter_key(input logic [1:0] r, input logic [1:0] c,
                             input logic [3:0] code, input logic [15:0] hex);
        exp_q.push_back('{code: code, hex: hex});
        press(r, c);
        wait_valid(60);
        key_active = 1'b0;
        wait_up(40);
    endtask

    logic [1:0]  seq_r   [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    logic [1:0]  seq_c   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0]  seq_code[5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4};
    logic [15:0] seq_hex [5] = '{16'h0001, 16'h0012, 16'h0123, 16'h123A, 16'h23A4};

    initial begin
        int cyc;

        // 1: reset state and idle scan sequence
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_col", 16'(col), 16'h000E);
        check("reset_hex", four_hex_out, 16'h0000);
        check("reset_code", 16'(key_code), 16'h0000);
        check("reset_valid", 16'(key_valid), 16'h0000);
        check("reset_down", 16'(key_down), 16'h0000);
        wait_col(4'b1101, 10, cyc);
        wait_col(4'b1011, 8, cyc);
        check("tick_period_c2", 16'(cyc), 16'd4);
        wait_col(4'b0111, 8, cyc);
        check("tick_period_c3", 16'(cyc), 16'd4);
        wait_col(4'b1110, 8, cyc);
        check("tick_period_wrap", 16'(cyc), 16'd4);
        check("idle_hex", four_hex_out, 16'h0000);

        // 2: press '5' and hold; exact accept latency from the c1 scan
        press(2'd1, 2'd1);
        exp_q.push_back('{code: 4'h5, hex: 16'h0005});
        wait_col(4'b1101, 8, cyc);
        repeat (11) @(posedge clk);
        #1;
        check("five_not_early", 16'(key_valid), 16'h0000);
        @(posedge clk); #1;
        check("five_valid", 16'(key_valid), 16'h0001);
        check("five_code", 16'(key_code), 16'h0005);
        check("five_down", 16'(key_down), 16'h0001);
        @(posedge clk); #1;
        check("five_single_pulse", 16'(key_valid), 16'h0000);
        repeat (20) @(posedge clk);
        #1;
        check("five_col_frozen", 16'(col), 16'h000D);
        check("five_still_down", 16'(key_down), 16'h0001);
        key_active = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("five_down_after_release", 16'(key_down), 16'h0001);
        wait_up(30);
        check("five_col_advance", 16'(col), 16'h000B);

        // 3: clr, then five keys shifted in
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_hex", four_hex_out, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            enter_key(seq_r[i], seq_c[i], seq_code[i], seq_hex[i]);
        end
        check("seq_final_hex", four_hex_out, 16'h23A4);

        // 4: one-tick bounce on r0/c0
        wait_col(4'b1110, 20, cyc);
        force_val = 4'b1110;
        force_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("bounce_col_frozen", 16'(col), 16'h000E);
        force_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bounce_col_advance", 16'(col), 16'h000D);
        check("bounce_down", 16'(key_down), 16'h0000);

        // 5: two rows low ignored; reset mid-debounce on '9'
        wait_col(4'b1110, 20, cyc);
        force_val = 4'b1010;
        force_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("multi_col_c1", 16'(col), 16'h000D);
        repeat (4) @(posedge clk);
        #1;
        check("multi_col_c2", 16'(col), 16'h000B);
        force_en = 1'b0;
        wait_col(4'b1110, 20, cyc);
        press(2'd2, 2'd2);
        wait_col(4'b1011, 12, cyc);
        repeat (5) @(posedge clk);
        #1;
        check("nine_debouncing_col", 16'(col), 16'h000B);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        key_active = 1'b0;
        check("midreset_col", 16'(col), 16'h000E);
        check("midreset_hex", four_hex_out, 16'h0000);
        check("midreset_down", 16'(key_down), 16'h0000);
        repeat (20) @(posedge clk);
        #1;

        // 6: clr coincident with the accept of 'F', then '7'
        enter_key(2'd0, 2'd0, 4'h1, 16'h0001);
        wait_col(4'b1110, 20, cyc);
        press(2'd3, 2'd1);
        exp_q.push_back('{code: 4'hF, hex: 16'h0000});
        wait_col(4'b1101, 8, cyc);
        repeat (11) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("f_clr_valid", 16'(key_valid), 16'h0001);
        check("f_clr_code", 16'(key_code), 16'h000F);
        check("f_clr_hex", four_hex_out, 16'h0000);
        key_active = 1'b0;
        wait_up(40);
        enter_key(2'd2, 2'd0, 4'h7, 16'h0007);
        check("seven_hex", four_hex_out, 16'h0007);

        repeat (5) @(posedge clk);
        #1;
        check("pending_events", 16'(exp_q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
